// File: rtl/adc_correction_pipe.sv
`timescale 1ns/1ps
// adc_correction_pipe: multi-channel piecewise-polynomial ADC corrector, Horner evaluation at one MAC per cycle.
// Build option ADC_CORR_SAT_EN: the final output saturates to OUT_W bits instead of wrapping.
module adc_correction_pipe #(
   parameter int IN_W   = 21,
   parameter int OUT_W  = 16,
   parameter int COEF_W = 32,
   parameter int FRAC   = 12,
   parameter int ORDER  = 4,
   parameter int NSEG   = 8,
   parameter int NCH    = 2,
   parameter int CH_W   = $clog2(NCH),
   parameter int CFG_AW = 10
) (
   input  logic              sys_clk_i,
   input  logic              reset_i,
   input  logic              srdyi,
   input  logic [CH_W-1:0]   ch_i,
   input  logic [IN_W-1:0]   adc_count_i,
   output logic              srdyo,
   output logic [CH_W-1:0]   ch_o,
   output logic [OUT_W-1:0]  data_o,
   output logic              busy_o,
   output logic              ovf_o,
   output logic              cfg_err_o,
   input  logic              flag_clr_i,
   input  logic              cfg_we_i,
   input  logic [CFG_AW-1:0] cfg_addr_i,
   input  logic [COEF_W-1:0] cfg_wdata_i
);

   localparam int SEG_W    = $clog2(NSEG);
   localparam int K_W      = $clog2(ORDER + 1);
   localparam int THR_BASE = NCH * NSEG * (ORDER + 1);
   localparam int CFG_END  = THR_BASE + NCH * (NSEG - 1);
   localparam int PROD_W   = COEF_W + IN_W + 1;
   localparam int Q_W      = COEF_W - FRAC;

   localparam logic signed [PROD_W-1:0] ACC_MAX = PROD_W'($signed({1'b0, {(COEF_W-1){1'b1}}}));
   localparam logic signed [PROD_W-1:0] ACC_MIN = PROD_W'($signed({1'b1, {(COEF_W-1){1'b0}}}));

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEG  = 2'd1;
   localparam logic [1:0] MAC  = 2'd2;
   localparam logic [1:0] OUT  = 2'd3;

   logic [1:0]               state_r;
   logic [IN_W-1:0]          x_r;
   logic [CH_W-1:0]          ch_r;
   logic [SEG_W-1:0]         seg_r, seg_s, rd_seg_s;
   logic [K_W-1:0]           k_r, rd_k_s;
   logic signed [COEF_W-1:0] acc_r, coef_rd_s, mac_s;
   logic signed [PROD_W-1:0] prod_s, sum_s;
   logic signed [COEF_W-1:0] coef_r [NCH][NSEG][ORDER+1];
   logic [IN_W-1:0]          thr_r  [NCH][NSEG-1];
   logic                     ch_ok_s, accept_s, drop_s, bad_ch_s, cfg_ok_s, cfg_bad_s;

   function automatic logic signed [COEF_W-1:0] sat_acc(input logic signed [PROD_W-1:0] v);
      if (v > ACC_MAX) begin
         sat_acc = ACC_MAX[COEF_W-1:0];
      end else if (v < ACC_MIN) begin
         sat_acc = ACC_MIN[COEF_W-1:0];
      end else begin
         sat_acc = v[COEF_W-1:0];
      end
   endfunction

   // q is the integer part of the accumulator (acc >>> FRAC)
   function automatic logic [OUT_W-1:0] conv(input logic signed [Q_W-1:0] q);
`ifdef ADC_CORR_SAT_EN
      logic signed [Q_W-1:0] hi, lo;
      hi = {{(Q_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      lo = ~hi;
      if (q > hi) begin
         conv = hi[OUT_W-1:0];
      end else if (q < lo) begin
         conv = lo[OUT_W-1:0];
      end else begin
         conv = q[OUT_W-1:0];
      end
`else
      conv = q[OUT_W-1:0];
`endif
   endfunction

   // Acceptance and error classification of sample and config strobes
   always_comb begin
      ch_ok_s  = ({1'b0, ch_i} < (CH_W+1)'(NCH));
      accept_s = 1'b0;
      bad_ch_s = 1'b0;
      drop_s   = 1'b0;
      if (state_r == IDLE) begin
         accept_s = srdyi && ch_ok_s;
         bad_ch_s = srdyi && !ch_ok_s;
      end else begin
         drop_s = srdyi;
      end
      cfg_ok_s  = cfg_we_i && (state_r == IDLE) && (cfg_addr_i < CFG_AW'(CFG_END));
      cfg_bad_s = cfg_we_i && !cfg_ok_s;
   end

   // Segment = number of thresholds of the latched channel at or below x
   always_comb begin
      seg_s = '0;
      for (int s = 0; s < NSEG - 1; s++) begin
         if (thr_r[ch_r][s] <= x_r) begin
            seg_s = seg_s + SEG_W'(1);
         end else begin
            seg_s = seg_s;
         end
      end
   end

   // Coefficient read port: SEG fetches the leading coefficient, MAC walks k downwards
   always_comb begin
      if (state_r == SEG) begin
         rd_seg_s = seg_s;
         rd_k_s   = K_W'(ORDER);
      end else begin
         rd_seg_s = seg_r;
         rd_k_s   = k_r;
      end
      coef_rd_s = coef_r[ch_r][rd_seg_s][rd_k_s];
   end

   // One Horner step: floor((acc * x) / 2^IN_W) + c[k], saturated to COEF_W
   always_comb begin
      prod_s = PROD_W'(acc_r) * PROD_W'($signed({1'b0, x_r}));
      sum_s  = (prod_s >>> IN_W) + PROD_W'(coef_rd_s);
      mac_s  = sat_acc(sum_s);
   end

   // Configuration store: coefficients then thresholds, writable only while idle
   always_ff @(posedge sys_clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < NSEG; s++) begin
               for (int k = 0; k <= ORDER; k++) begin
                  coef_r[c][s][k] <= '0;
               end
            end
            for (int s = 0; s < NSEG - 1; s++) begin
               thr_r[c][s] <= '1;
            end
         end
      end else if (cfg_ok_s) begin
         for (int c = 0; c < NCH; c++) begin
            for (int s = 0; s < NSEG; s++) begin
               for (int k = 0; k <= ORDER; k++) begin
                  if (cfg_addr_i == CFG_AW'((c * NSEG + s) * (ORDER + 1) + k)) begin
                     coef_r[c][s][k] <= cfg_wdata_i;
                  end
               end
            end
            for (int s = 0; s < NSEG - 1; s++) begin
               if (cfg_addr_i == CFG_AW'(THR_BASE + c * (NSEG - 1) + s)) begin
                  thr_r[c][s] <= cfg_wdata_i[IN_W-1:0];
               end
            end
         end
      end
   end

   // Sequencer and result registers; srdyo rises with the final MAC so it covers the OUT cycle
   always_ff @(posedge sys_clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_r <= IDLE;
         x_r     <= '0;
         ch_r    <= '0;
         seg_r   <= '0;
         k_r     <= '0;
         acc_r   <= '0;
         srdyo   <= 1'b0;
         busy_o  <= 1'b0;
         data_o  <= '0;
         ch_o    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               srdyo <= 1'b0;
               if (accept_s) begin
                  x_r     <= adc_count_i;
                  ch_r    <= ch_i;
                  busy_o  <= 1'b1;
                  state_r <= SEG;
               end
            end
            SEG: begin
               seg_r   <= seg_s;
               acc_r   <= coef_rd_s;
               k_r     <= K_W'(ORDER - 1);
               state_r <= MAC;
            end
            MAC: begin
               acc_r <= mac_s;
               if (k_r == K_W'(0)) begin
                  data_o  <= conv(mac_s[COEF_W-1:FRAC]);
                  ch_o    <= ch_r;
                  srdyo   <= 1'b1;
                  state_r <= OUT;
               end else begin
                  k_r <= k_r - K_W'(1);
               end
            end
            OUT: begin
               srdyo   <= 1'b0;
               busy_o  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               srdyo   <= 1'b0;
               busy_o  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Sticky flags; a set event in the same cycle as flag_clr_i wins
   always_ff @(posedge sys_clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ovf_o     <= 1'b0;
         cfg_err_o <= 1'b0;
      end else begin
         if (drop_s) begin
            ovf_o <= 1'b1;
         end else if (flag_clr_i) begin
            ovf_o <= 1'b0;
         end
         if (cfg_bad_s || bad_ch_s) begin
            cfg_err_o <= 1'b1;
         end else if (flag_clr_i) begin
            cfg_err_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_correction_pipe.sv
`timescale 1ns/1ps
// Randomized self-checking bench for adc_correction_pipe against an arithmetic reference model.
module tb_adc_correction_pipe;

   localparam int NCH = 2, NSEG = 8, ORDER = 4;
   localparam int THR_BASE = NCH * NSEG * (ORDER + 1);

   logic        clk = 1'b0;
   logic        reset_i = 1'b0;
   logic        srdyi = 1'b0;
   logic [0:0]  ch_i = 1'b0;
   logic [20:0] adc_count_i = 21'd0;
   logic        srdyo;
   logic [0:0]  ch_o;
   logic [15:0] data_o;
   logic        busy_o, ovf_o, cfg_err_o;
   logic        flag_clr_i = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic [9:0]  cfg_addr_i = 10'd0;
   logic [31:0] cfg_wdata_i = 32'd0;

   int vectors = 0;
   int miscompares = 0;
   longint coef_m [NCH][NSEG][ORDER+1];
   longint thr_m  [NCH][NSEG-1];

   always #5 clk = ~clk;

   adc_correction_pipe dut (
      .sys_clk_i(clk), .reset_i(reset_i), .srdyi(srdyi), .ch_i(ch_i), .adc_count_i(adc_count_i),
      .srdyo(srdyo), .ch_o(ch_o), .data_o(data_o), .busy_o(busy_o), .ovf_o(ovf_o),
      .cfg_err_o(cfg_err_o), .flag_clr_i(flag_clr_i), .cfg_we_i(cfg_we_i),
      .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   function automatic logic [15:0] model_out(input int ch, input longint x);
      int seg;
      longint acc, y;
      seg = 0;
      for (int s = 0; s < NSEG - 1; s++) if (thr_m[ch][s] <= x) seg++;
      acc = coef_m[ch][seg][ORDER];
      for (int k = ORDER - 1; k >= 0; k--) acc = sat32(fdiv(acc * x, 64'sd2097152) + coef_m[ch][seg][k]);
      y = fdiv(acc, 64'sd4096);
`ifdef ADC_CORR_SAT_EN
      if (y > 64'sd32767) y = 64'sd32767;
      else if (y < -64'sd32768) y = -64'sd32768;
`endif
      return y[15:0];
   endfunction

   function automatic int coef_addr(input int ch, input int seg, input int k);
      return (ch * NSEG + seg) * (ORDER + 1) + k;
   endfunction

   function automatic int thr_addr(input int ch, input int s);
      return THR_BASE + ch * (NSEG - 1) + (s - 1);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         for (int s = 0; s < NSEG; s++) for (int k = 0; k <= ORDER; k++) coef_m[c][s][k] = 0;
         for (int s = 0; s < NSEG - 1; s++) thr_m[c][s] = 64'h1F_FFFF;
      end
   endtask

   task automatic model_apply(input int addr, input logic [31:0] data);
      if (addr < THR_BASE)
         coef_m[addr / 40][(addr % 40) / 5][addr % 5] = longint'($signed(data));
      else if (addr < THR_BASE + NCH * (NSEG - 1))
         thr_m[(addr - THR_BASE) / 7][(addr - THR_BASE) % 7] = longint'(data[20:0]);
   endtask

   task automatic cfg_write(input int addr, input logic [31:0] data);
      cfg_we_i = 1'b1; cfg_addr_i = addr[9:0]; cfg_wdata_i = data;
      tick();
      cfg_we_i = 1'b0;
      model_apply(addr, data);
   endtask

   task automatic send_and_check(input string tag, input int ch, input int x,
                                 input bit wr, input int waddr, input logic [31:0] wdata);
      logic [15:0] exp_d;
      int n;
      if (wr) model_apply(waddr, wdata);
      exp_d = model_out(ch, longint'(x));
      srdyi = 1'b1; ch_i = ch[0:0]; adc_count_i = x[20:0];
      if (wr) begin
         cfg_we_i = 1'b1; cfg_addr_i = waddr[9:0]; cfg_wdata_i = wdata;
      end
      tick();
      srdyi = 1'b0; cfg_we_i = 1'b0;
      n = 1;
      while (srdyo !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check_val({tag, "_latency"}, n, 6);
      check_val({tag, "_data"}, data_o, exp_d);
      check_val({tag, "_ch"}, ch_o, ch);
      tick();
      check_val({tag, "_pulse_end"}, srdyo, 0);
   endtask

   function automatic logic [31:0] rand_coef();
      logic [31:0] v;
      case ($urandom_range(0, 3))
         0: v = $urandom;
         1: begin v = $urandom_range(0, 32'h0100_0000); v = v - 32'h0080_0000; end
         2: v = 32'd0;
         default: begin v = $urandom_range(0, 32'h4000_0000); v = v - 32'h2000_0000; end
      endcase
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cnt, ch, x, j, a;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_srdyo", srdyo, 0);
      check_val("rst_busy", busy_o, 0);
      check_val("rst_ovf", ovf_o, 0);
      check_val("rst_cfg_err", cfg_err_o, 0);
      check_val("rst_data", data_o, 0);
      check_val("rst_ch", ch_o, 0);
      reset_i = 1'b1;
      tick();

      // T1 constant polynomial
      cfg_write(coef_addr(0, 0, 0), 32'd100 << 12);
      send_and_check("t1", 0, 32'h0000_1234, 1'b0, 0, 32'd0);
      check_val("t1_const", data_o, 16'd100);
      // T2 linear term, channel 1
      cfg_write(coef_addr(1, 0, 1), 32'd1000 << 12);
      send_and_check("t2", 1, 32'h0010_0000, 1'b0, 0, 32'd0);
      check_val("t2_linear", data_o, 16'd500);
      // T3 segment boundary
      cfg_write(thr_addr(0, 1), 32'h0008_0000);
      cfg_write(coef_addr(0, 0, 0), 32'd10 << 12);
      cfg_write(coef_addr(0, 1, 0), 32'd20 << 12);
      send_and_check("t3_below", 0, 32'h0007_FFFF, 1'b0, 0, 32'd0);
      check_val("t3_seg0", data_o, 16'd10);
      send_and_check("t3_at", 0, 32'h0008_0000, 1'b0, 0, 32'd0);
      check_val("t3_seg1", data_o, 16'd20);
      // T4 output range
      cfg_write(coef_addr(0, 0, 0), 32'd40000 << 12);
      send_and_check("t4", 0, 32'h0000_1234, 1'b0, 0, 32'd0);
`ifdef ADC_CORR_SAT_EN
      check_val("t4_range", data_o, 16'h7FFF);
`else
      check_val("t4_range", data_o, 16'h9C40);
`endif
      // write and sample in the same idle cycle: sample sees the new coefficient
      send_and_check("same_cyc", 0, 32'h0000_1234, 1'b1, coef_addr(0, 0, 0), 32'd123 << 12);
      check_val("same_cyc_new", data_o, 16'd123);

      // T5 overrun and dropped config write
      srdyi = 1'b1; ch_i = 1'b0; adc_count_i = 21'h001234;
      tick();
      srdyi = 1'b0;
      check_val("t5_busy", busy_o, 1);
      tick();
      cfg_we_i = 1'b1; cfg_addr_i = coef_addr(0, 0, 0); cfg_wdata_i = 32'd999 << 12;
      tick();
      cfg_we_i = 1'b0;
      check_val("t5_cfg_err", cfg_err_o, 1);
      check_val("t5_ovf_pre", ovf_o, 0);
      srdyi = 1'b1; adc_count_i = 21'h005555;
      tick();
      srdyi = 1'b0;
      check_val("t5_ovf", ovf_o, 1);
      check_val("t5_no_early", srdyo, 0);
      tick();
      tick();
      check_val("t5_srdyo", srdyo, 1);
      check_val("t5_data", data_o, 16'd123);
      tick();
      check_val("t5_pulse_end", srdyo, 0);
      check_val("t5_idle", busy_o, 0);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (srdyo === 1'b1) cnt++;
      end
      check_val("t5_single_result", cnt, 0);
      flag_clr_i = 1'b1;
      tick();
      flag_clr_i = 1'b0;
      check_val("t5_ovf_clr", ovf_o, 0);
      check_val("t5_err_clr", cfg_err_o, 0);
      send_and_check("t5_after", 0, 32'h0000_1234, 1'b0, 0, 32'd0);
      // set beats clear
      cfg_we_i = 1'b1; cfg_addr_i = 10'd1000; flag_clr_i = 1'b1;
      tick();
      cfg_we_i = 1'b0; flag_clr_i = 1'b0;
      check_val("set_wins", cfg_err_o, 1);
      flag_clr_i = 1'b1;
      tick();
      flag_clr_i = 1'b0;
      check_val("clr_after_set", cfg_err_o, 0);

      // T6 reset in the middle of MAC
      cfg_write(coef_addr(0, 0, 0), 32'd77 << 12);
      srdyi = 1'b1; ch_i = 1'b0; adc_count_i = 21'h001234;
      tick();
      srdyi = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
      #1;
      check_val("t6_busy", busy_o, 0);
      check_val("t6_srdyo", srdyo, 0);
      tick();
      tick();
      reset_i = 1'b1;
      model_reset();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (srdyo === 1'b1) cnt++;
      end
      check_val("t6_no_result", cnt, 0);
      send_and_check("t6_after", 0, 32'h0000_1234, 1'b0, 0, 32'd0);

      // randomized configurations and samples
      for (int it = 0; it < 60; it++) begin
         ch = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: for (int n = 0; n < 6; n++)
                  cfg_write(coef_addr(ch, $urandom_range(0, NSEG - 1), $urandom_range(0, ORDER)), rand_coef());
            1: cfg_write(thr_addr(ch, $urandom_range(1, NSEG - 1)), $urandom);
            2: for (int k = 0; k <= ORDER; k++) cfg_write(coef_addr(ch, $urandom_range(0, NSEG - 1), k), rand_coef());
            default: ;
         endcase
         x = $urandom_range(0, 32'h001F_FFFF);
         if ($urandom_range(0, 2) == 0) begin
            j = $urandom_range(0, NSEG - 2);
            x = int'(thr_m[ch][j]) - int'($urandom_range(0, 1));
            x = x & 32'h001F_FFFF;
         end
         if ($urandom_range(0, 4) == 0)
            send_and_check("rnd_wr", ch, x, 1'b1, coef_addr(ch, $urandom_range(0, NSEG - 1), $urandom_range(0, ORDER)), rand_coef());
         else
            send_and_check("rnd", ch, x, 1'b0, 0, 32'd0);
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom_range(THR_BASE + NCH * (NSEG - 1), 1023);
            cfg_write(a, $urandom);
            check_val("rnd_bad_addr", cfg_err_o, 1);
            flag_clr_i = 1'b1;
            tick();
            flag_clr_i = 1'b0;
            check_val("rnd_bad_clr", cfg_err_o, 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
